// File: rtl/seg7_scan_2digit_if.sv
// Digit/display bundle between the BCD counter side and the two-digit scan driver.
// The master drives the digits and the blank control; the slave (the driver) returns the display pins.
interface seg7_scan_2digit_if;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       blank;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;
  logic       frame_done;

  modport master (
    output ones, tens, blank,
    input  seg, an, err, frame_done
  );

  modport slave (
    input  ones, tens, blank,
    output seg, an, err, frame_done
  );
endinterface

// File: rtl/seg7_scan_2digit.sv
// Two-digit multiplexed seven-segment driver: per-frame snapshot of the BCD pair,
// alternating digit slots with dead-time, leading-zero blanking and invalid-BCD flag.
module seg7_scan_2digit #(
  parameter int REFRESH_DIV   = 50000,
  parameter int DEAD_CYCLES   = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  seg7_scan_2digit_if.slave bus
);

  localparam int             P_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [P_W-1:0] P_LAST = P_W'(REFRESH_DIV - 1);
  localparam logic [P_W-1:0] P_DEAD = P_W'(DEAD_CYCLES);

  typedef enum logic {
    SLOT_ONES = 1'b0,
    SLOT_TENS = 1'b1
  } slot_t;

  slot_t          slot_reg, slot_next;
  logic [P_W-1:0] p_reg, p_next;
  logic [3:0]     sh_ones_reg, sh_ones_next;
  logic [3:0]     sh_tens_reg, sh_tens_next;
  logic           frame_done_reg, frame_done_next;
  logic [6:0]     seg_reg, seg_next;
  logic [1:0]     an_reg, an_next;
  logic           err_reg, err_next;

  logic           tick;
  logic           snap;
  logic [3:0]     digit_val;
  logic           lead_blank;
  logic           digit_on;
  logic [6:0]     seg_act;
  logic [1:0]     an_act;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b1000000;
    case (d)
      4'd0: s = 7'b0111111;
      4'd1: s = 7'b0000110;
      4'd2: s = 7'b1011011;
      4'd3: s = 7'b1001111;
      4'd4: s = 7'b1100110;
      4'd5: s = 7'b1101101;
      4'd6: s = 7'b1111101;
      4'd7: s = 7'b0000111;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  assign tick   = (p_reg == P_LAST);
  assign p_next = tick ? '0 : p_reg + 1'b1;

  always_comb begin
    slot_next = slot_reg;
    if (tick) begin
      case (slot_reg)
        SLOT_ONES: slot_next = SLOT_TENS;
        SLOT_TENS: slot_next = SLOT_ONES;
        default:   slot_next = SLOT_ONES;
      endcase
    end
  end

  // The pair is captured only at the frame boundary so a mid-frame update never tears.
  assign snap            = tick && (slot_reg == SLOT_TENS);
  assign sh_ones_next    = snap ? bus.ones : sh_ones_reg;
  assign sh_tens_next    = snap ? bus.tens : sh_tens_reg;
  assign frame_done_next = snap;

  always_comb begin
    digit_val  = (slot_reg == SLOT_ONES) ? sh_ones_reg : sh_tens_reg;
    lead_blank = BLANK_LEADING && (slot_reg == SLOT_TENS) && (sh_tens_reg == 4'd0);
    digit_on   = (p_reg >= P_DEAD) && !bus.blank && !lead_blank;
    seg_act    = 7'b0000000;
    an_act     = 2'b00;
    if (digit_on) begin
      seg_act = decode(digit_val);
      an_act  = (slot_reg == SLOT_ONES) ? 2'b01 : 2'b10;
    end
  end

  // Polarity applied bitwise so an all-off digit naturally becomes all-inactive seg.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_seg_pol
      assign seg_next[gi] = seg_act[gi] ^ ACTIVE_LOW;
    end
    for (gi = 0; gi < 2; gi++) begin : g_an_pol
      assign an_next[gi] = an_act[gi] ^ ACTIVE_LOW;
    end
  endgenerate

  assign err_next = (sh_ones_reg > 4'd9) || (sh_tens_reg > 4'd9);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_reg <= SLOT_ONES;
    end else begin
      slot_reg <= slot_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_reg          <= '0;
      sh_ones_reg    <= 4'd0;
      sh_tens_reg    <= 4'd0;
      frame_done_reg <= 1'b0;
      seg_reg        <= {7{ACTIVE_LOW}};
      an_reg         <= {2{ACTIVE_LOW}};
      err_reg        <= 1'b0;
    end else begin
      p_reg          <= p_next;
      sh_ones_reg    <= sh_ones_next;
      sh_tens_reg    <= sh_tens_next;
      frame_done_reg <= frame_done_next;
      seg_reg        <= seg_next;
      an_reg         <= an_next;
      err_reg        <= err_next;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.an         = an_reg;
  assign bus.err        = err_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_2digit.sv
// Directed bench for the two-digit scan driver: REFRESH_DIV=8, DEAD_CYCLES=2, active-low,
// with a second instance that keeps leading zeros visible.
module tb_seg7_scan_2digit;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;

  seg7_scan_2digit_if bus ();
  seg7_scan_2digit_if bus_nb ();

  assign bus_nb.ones  = bus.ones;
  assign bus_nb.tens  = bus.tens;
  assign bus_nb.blank = bus.blank;

  seg7_scan_2digit #(
    .REFRESH_DIV  (8),
    .DEAD_CYCLES  (2),
    .ACTIVE_LOW   (1'b1),
    .BLANK_LEADING(1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  seg7_scan_2digit #(
    .REFRESH_DIV  (8),
    .DEAD_CYCLES  (2),
    .ACTIVE_LOW   (1'b1),
    .BLANK_LEADING(1'b0)
  ) dut_nb (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_nb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at the sample where frame_done is high (or just after reset release) and walks
  // 16 clocks: j=1,2 and 9,10 are dead time, 3..8 the ones slot, 11..16 the tens slot.
  task automatic check_frame(input string tag,
                             input logic [6:0] o_seg, input logic [1:0] o_an,
                             input logic [6:0] t_seg, input logic [1:0] t_an,
                             input logic [6:0] nt_seg, input logic [1:0] nt_an,
                             input logic e_err, input int chg_j,
                             input logic [3:0] n_ones, input logic [3:0] n_tens);
    logic [6:0] e_seg, e_nseg;
    logic [1:0] e_an, e_nan;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 1 || j == 2 || j == 9 || j == 10) begin
        e_seg = 7'h7F; e_an = 2'b11; e_nseg = 7'h7F; e_nan = 2'b11;
      end else if (j <= 8) begin
        e_seg = o_seg; e_an = o_an; e_nseg = o_seg; e_nan = o_an;
      end else begin
        e_seg = t_seg; e_an = t_an; e_nseg = nt_seg; e_nan = nt_an;
      end
      chk($sformatf("%s_j%0d_an", tag, j), {6'd0, bus.an}, {6'd0, e_an});
      chk($sformatf("%s_j%0d_seg", tag, j), {1'b0, bus.seg}, {1'b0, e_seg});
      chk($sformatf("%s_j%0d_nb_an", tag, j), {6'd0, bus_nb.an}, {6'd0, e_nan});
      chk($sformatf("%s_j%0d_nb_seg", tag, j), {1'b0, bus_nb.seg}, {1'b0, e_nseg});
      chk($sformatf("%s_j%0d_fd", tag, j), {7'd0, bus.frame_done}, {7'd0, (j == 16)});
      chk($sformatf("%s_j%0d_err", tag, j), {7'd0, bus.err}, {7'd0, e_err});
      if (j == chg_j) begin
        bus.ones = n_ones;
        bus.tens = n_tens;
      end
    end
    $display("frame %s checked", tag);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    bus.ones  = 4'd7;
    bus.tens  = 4'd4;
    bus.blank = 1'b0;

    repeat (5) @(negedge clk);
    chk("rst_seg", {1'b0, bus.seg}, 8'h7F);
    chk("rst_an", {6'd0, bus.an}, 8'h03);
    chk("rst_err", {7'd0, bus.err}, 8'h00);
    chk("rst_fd", {7'd0, bus.frame_done}, 8'h00);
    chk("rst_nb_an", {6'd0, bus_nb.an}, 8'h03);
    $display("reset state checked");
    reset_n = 1'b1;

    // First frame shows shadow 00; the 4/7 on the inputs is captured at its end.
    check_frame("f00", 7'h40, 2'b10, 7'h7F, 2'b11, 7'h40, 2'b01, 1'b0, 0, 4'd0, 4'd0);
    check_frame("f47", 7'h78, 2'b10, 7'h19, 2'b01, 7'h19, 2'b01, 1'b0, 6, 4'd9, 4'd3);
    check_frame("f39", 7'h10, 2'b10, 7'h30, 2'b01, 7'h30, 2'b01, 1'b0, 6, 4'd5, 4'd0);
    check_frame("f05", 7'h12, 2'b10, 7'h7F, 2'b11, 7'h40, 2'b01, 1'b0, 6, 4'd12, 4'd1);
    check_frame("fbad", 7'h3F, 2'b10, 7'h79, 2'b01, 7'h79, 2'b01, 1'b1, 6, 4'd3, 4'd1);
    check_frame("f13", 7'h30, 2'b10, 7'h79, 2'b01, 7'h79, 2'b01, 1'b0, 0, 4'd0, 4'd0);

    // Blank held across a frame boundary; snapshot cadence must not change.
    repeat (4) @(negedge clk);
    chk("blk_pre_an", {6'd0, bus.an}, 8'h02);
    bus.blank = 1'b1;
    for (int j = 5; j <= 16; j++) begin
      @(negedge clk);
      chk($sformatf("blk_j%0d_an", j), {6'd0, bus.an}, 8'h03);
      chk($sformatf("blk_j%0d_seg", j), {1'b0, bus.seg}, 8'h7F);
      chk($sformatf("blk_j%0d_fd", j), {7'd0, bus.frame_done}, {7'd0, (j == 16)});
    end
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      chk($sformatf("blk2_j%0d_an", j), {6'd0, bus.an}, 8'h03);
      chk($sformatf("blk2_j%0d_fd", j), {7'd0, bus.frame_done}, 8'h00);
    end
    bus.blank = 1'b0;
    @(negedge clk);
    chk("unblk_an", {6'd0, bus.an}, 8'h02);
    chk("unblk_seg", {1'b0, bus.seg}, 8'h30);
    $display("blanking checked");

    // Asynchronous reset in the middle of the tens slot.
    repeat (4) @(negedge clk);
    chk("mid_tens_an", {6'd0, bus.an}, 8'h01);
    chk("mid_tens_seg", {1'b0, bus.seg}, 8'h79);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_seg", {1'b0, bus.seg}, 8'h7F);
    chk("arst_an", {6'd0, bus.an}, 8'h03);
    chk("arst_err", {7'd0, bus.err}, 8'h00);
    chk("arst_fd", {7'd0, bus.frame_done}, 8'h00);
    chk("arst_nb_an", {6'd0, bus_nb.an}, 8'h03);
    $display("async reset checked");
    @(negedge clk);
    reset_n = 1'b1;
    check_frame("frst", 7'h40, 2'b10, 7'h7F, 2'b11, 7'h40, 2'b01, 1'b0, 0, 4'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_2digit.md
Name: seg7_scan_2digit

Overview:
Time-multiplexed driver for a two-digit common-anode seven-segment display. It consumes the BCD ones/tens digit pair produced by the two-digit counter. Each frame it snapshots the pair, scans the two digits alternately at a divided refresh rate with dead-time between digits, blanks a leading zero, and flags invalid BCD. It sits between the counter and the board display pins.

Parameters:
REFRESH_DIV, 50000, clocks per digit slot; legal range >= 4.
DEAD_CYCLES, 4, clocks with both digits off at each slot boundary; must satisfy 1 <= DEAD_CYCLES < REFRESH_DIV-1.
ACTIVE_LOW, 1, 1 = seg and an are active-low; 0 = active-high.
BLANK_LEADING, 1, 1 = suppress the tens digit when it is 0.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
ones  input  4  BCD ones digit
tens  input  4  BCD tens digit
blank  input  1  1 = all digits dark; scanning continues
seg  output  7  segments {g,f,e,d,c,b,a}, bit0 = a
an  output  2  digit enables; an[0] = ones, an[1] = tens
err  output  1  1 while either shadowed digit is > 9
frame_done  output  1  one-clock pulse at each snapshot

Behaviour:
- Clock and reset: single clock domain. reset_n is asynchronous, active-low. Release is assumed synchronous to clk upstream.
- Reset values:
  - prescaler p = 0; slot s = ONES; shadow ones/tens = 0.
  - seg and an all inactive (ACTIVE_LOW=1: seg = 7'h7F, an = 2'b11).
  - err = 0; frame_done = 0.
- Reset asserted mid-operation returns every register to these values immediately.
- Prescaler:
  - p counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (p == REFRESH_DIV-1).
- Slot state machine (two states, ONES and TENS):
  - On tick, ONES goes to TENS and TENS goes to ONES. No other transitions.
  - Slot length is REFRESH_DIV clocks; frame length is 2*REFRESH_DIV clocks.
- Snapshot:
  - On tick while s == TENS, shadow registers capture the ones/tens inputs.
  - frame_done is registered high for exactly that one clock.
  - Input changes between snapshots have no effect on the display (no tearing).
  - The first frame after reset displays shadow = 00.
- Digit enable: the selected digit drives when p >= DEAD_CYCLES, blank == 0, and the digit is not leading-blanked. Otherwise both digits are off.
- Leading blank: with BLANK_LEADING = 1 and shadow tens == 0, the tens digit stays off for the whole tens slot. The ones digit always shows, including for value 00.
- Output registration:
  - seg, an and err are registered, one clock after the p/s/shadow/blank values they depict.
  - Consequence: exactly DEAD_CYCLES consecutive clocks with an fully inactive at each slot boundary.
  - blank takes effect on an one clock after it is sampled.
- Decode (active-high form, before polarity):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - 10..15 = dash 1000000 (segment g only)
- Polarity: when ACTIVE_LOW = 1, both seg and an are inverted. When an is inactive, seg is driven all-inactive.
- err: combinational from shadow, then registered. It is 1 while shadow ones > 9 or shadow tens > 9, and it is not sticky.
- Simultaneous events: blank asserted on a tick clock still performs the snapshot and the frame_done pulse.

Test Plan:
Bench parameters for all scenarios: REFRESH_DIV = 8, DEAD_CYCLES = 2, ACTIVE_LOW = 1, BLANK_LEADING = 1.
1. Reset behaviour: hold reset_n low 5 clocks -> seg = 7F, an = 11, err = 0, frame_done = 0. Pulse reset_n low mid-tens-slot -> same values asynchronously; scanning restarts in the ONES slot with p = 0.
2. Normal scan: tens = 4, ones = 7, wait for the first frame_done -> ones slot shows an = 10, seg = 7'b1111000; tens slot shows an = 01, seg = 7'b0011001. an = 11 for exactly 2 clocks at every slot boundary. frame_done pulses every 16 clocks.
3. Snapshot and no tearing: change inputs to 3/9 mid-frame -> display keeps 4/7 until the next frame_done, then shows 3/9 in the following frame.
4. Leading zero: tens = 0, ones = 5 -> tens slot an = 11 throughout, ones slot seg = 7'b0010010. With BLANK_LEADING = 0 -> tens slot seg = 7'b1000000, an = 01.
5. Invalid BCD: ones = 12 -> after snapshot, ones slot seg = 7'b0111111 and err = 1. Then ones = 3 -> err = 0 one clock after the next snapshot.
6. Blanking: assert blank mid-slot -> an = 11 on the next clock and for as long as blank is held. frame_done keeps its 16-clock cadence. Deassert -> the current digit reappears one clock later, provided p >= DEAD_CYCLES.
